// File: rtl/ram_rd_stream_pkg.sv
// Shared types and constants for the port-B read stream engine.
package ram_rd_stream_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_e;

   localparam int unsigned STAT_W = 32;

   // Width of a counter that must hold the values 0..depth inclusive
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ram_rd_stream_if.sv
// Command, RAM port-B and output stream signals of the read stream engine.
interface ram_rd_stream_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LEN_WIDTH  = 10
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_len;

   logic                  ram_en;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_data;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic                  last;

   // Engine side
   modport master (
      input  cmd_valid, cmd_addr, cmd_len, ram_data, ready,
      output cmd_ready, ram_en, ram_addr, valid, data, last
   );

   // Environment side: command source, RAM and stream sink
   modport slave (
      output cmd_valid, cmd_addr, cmd_len, ram_data, ready,
      input  cmd_ready, ram_en, ram_addr, valid, data, last
   );
endinterface

// File: rtl/ram_rd_stream_fifo.sv
// rd_skid_fifo: register FIFO buffering returned RAM words ahead of the stream output.
module rd_skid_fifo
   import ram_rd_stream_pkg::*;
#(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 3
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      push_i,
   input  logic [WIDTH-1:0]          data_i,
   input  logic                      pop_i,
   output logic [WIDTH-1:0]          data_o,
   output logic                      valid_o,
   output logic [cnt_w(DEPTH)-1:0]   count_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             pop;

   assign pop     = pop_i && (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

   // Storage is cleared on reset so the stream outputs read 0 while idle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         if (push_i && !pop)      count_q <= count_q + CNT_W'(1);
         else if (!push_i && pop) count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/ram_rd_stream.sv
// Port-B read engine: turns {addr,len} commands into credit-limited RAM reads and a valid/ready stream.
// Build option: define RAM_RD_STREAM_STATS_EN to enable the delivered-word and stall counters.
module ram_rd_stream
   import ram_rd_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned RAM_DEPTH  = 1024,
   parameter int unsigned OUT_DELAY  = 1,
   parameter int unsigned LEN_WIDTH  = 10,
   parameter int unsigned SKID_DEPTH = OUT_DELAY + 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   ram_rd_stream_if.master   bus,
   output logic              o_busy,
   output logic [STAT_W-1:0] o_stat_words,
   output logic [STAT_W-1:0] o_stat_stall
);
   localparam int unsigned CNT_W = cnt_w(SKID_DEPTH);
   localparam int unsigned SUM_W = CNT_W + 1;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_q, cur_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic [CNT_W-1:0]      inflight_q, inflight_d;
   logic                  pipe_vld_q  [OUT_DELAY];
   logic                  pipe_last_q [OUT_DELAY];

   logic                  issue;
   logic                  credit_ok;
   logic                  push;
   logic                  pop;
   logic [CNT_W-1:0]      buf_count;
   logic                  buf_valid;
   logic [DATA_WIDTH:0]   buf_out;

   // Credit counts only registered occupancy, so a word popped this cycle frees space next cycle
   assign credit_ok = (SUM_W'(inflight_q) + SUM_W'(buf_count)) < SUM_W'(SKID_DEPTH);
   assign push      = pipe_vld_q[OUT_DELAY-1];

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      rem_d       = rem_q;
      issue       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               state_d = ST_READ;
               cur_d   = bus.cmd_addr;
               rem_d   = bus.cmd_len;
            end
         end
         ST_READ: begin
            if (credit_ok) begin
               issue = 1'b1;
               cur_d = (cur_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : cur_q + ADDR_WIDTH'(1);
               if (rem_q == '0) state_d = ST_IDLE;
               else             rem_d   = rem_q - LEN_WIDTH'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
      inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(push);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         rem_q       <= '0;
         cmd_ready_q <= 1'b0;
         inflight_q  <= '0;
         for (int i = 0; i < int'(OUT_DELAY); i++) begin
            pipe_vld_q[i]  <= 1'b0;
            pipe_last_q[i] <= 1'b0;
         end
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         rem_q       <= rem_d;
         cmd_ready_q <= cmd_ready_d;
         inflight_q  <= inflight_d;
         pipe_vld_q[0]  <= issue;
         pipe_last_q[0] <= issue && (rem_q == '0);
         for (int i = 1; i < int'(OUT_DELAY); i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_last_q[i] <= pipe_last_q[i-1];
         end
      end
   end

   rd_skid_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (SKID_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push_i  (push),
      .data_i  ({pipe_last_q[OUT_DELAY-1], bus.ram_data}),
      .pop_i   (pop),
      .data_o  (buf_out),
      .valid_o (buf_valid),
      .count_o (buf_count)
   );

   assign pop          = buf_valid && bus.ready;
   assign bus.cmd_ready = cmd_ready_q;
   assign bus.ram_en    = issue;
   assign bus.ram_addr  = cur_q;
   assign bus.valid     = buf_valid;
   assign bus.data      = buf_out[DATA_WIDTH-1:0];
   assign bus.last      = buf_out[DATA_WIDTH];
   assign o_busy        = (state_q != ST_IDLE) || (inflight_q != '0) || (buf_count != '0);

`ifdef RAM_RD_STREAM_STATS_EN
   logic [STAT_W-1:0] words_q, stall_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         words_q <= '0;
         stall_q <= '0;
      end else begin
         if (buf_valid && bus.ready)  words_q <= words_q + STAT_W'(1);
         if (buf_valid && !bus.ready) stall_q <= stall_q + STAT_W'(1);
      end
   end

   assign o_stat_words = words_q;
   assign o_stat_stall = stall_q;
`else
   assign o_stat_words = '0;
   assign o_stat_stall = '0;
`endif

endmodule

// File: tb/tb_ram_rd_stream.sv
// Randomized bench for ram_rd_stream against a queue-based reference of the expected word stream.
module tb_ram_rd_stream;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 10;
   localparam int unsigned LW    = 10;
   localparam int unsigned DEPTH = 1000;
   localparam int unsigned DLY   = 2;
   localparam int unsigned SKID  = DLY + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic busy;
   logic [31:0] stat_words, stat_stall;

   ram_rd_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus_if ();

   ram_rd_stream #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RAM_DEPTH  (DEPTH),
      .OUT_DELAY  (DLY),
      .LEN_WIDTH  (LW),
      .SKID_DEPTH (SKID)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .bus          (bus_if),
      .o_busy       (busy),
      .o_stat_words (stat_words),
      .o_stat_stall (stat_stall)
   );

   always #5 clk = ~clk;

   // RAM model: mem[k]=k, read data visible DLY cycles after the enable
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_pipe [DLY];
   always @(posedge clk) begin
      for (int i = int'(DLY) - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      if (bus_if.ram_en && (int'(bus_if.ram_addr) < int'(DEPTH))) rd_pipe[0] <= mem[bus_if.ram_addr];
      else                                                       rd_pipe[0] <= 32'hDEAD_BEEF;
   end
   assign bus_if.ram_data = rd_pipe[DLY-1];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cyc, first_cyc, last_hs_cyc;
   bit seen_first;
   int issued, delivered, words_seen, stalls_seen;
   int ready_mode = 0;
   logic [DW:0] exp_q[$];
   int en_cyc[$];
   bit prev_stall;
   logic [DW-1:0] prev_data;
   logic prev_last;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Sink ready pattern: 0 always ready, 1 random, 2 toggle, 4 never ready
   initial begin
      bus_if.ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       bus_if.ready = 1'($urandom % 2);
            2:       bus_if.ready = ~bus_if.ready;
            4:       bus_if.ready = 1'b0;
            default: bus_if.ready = 1'b1;
         endcase
      end
   end

   // Stream monitor: ordering, last flags, hold-under-stall and outstanding-read bound
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (bus_if.ram_en) begin
               issued++;
               en_cyc.push_back(cyc);
            end
            if (prev_stall) begin
               chk("hold_valid", 64'(bus_if.valid), 64'(1));
               chk("hold_data", 64'(bus_if.data), 64'(prev_data));
               chk("hold_last", 64'(bus_if.last), 64'(prev_last));
            end
            if (bus_if.valid && bus_if.ready) begin
               delivered++;
               words_seen++;
               if (!seen_first) begin
                  seen_first = 1'b1;
                  first_cyc  = cyc;
               end
               last_hs_cyc = cyc;
               if (exp_q.size() == 0) begin
                  chk("extra_word_qsize", 64'(exp_q.size()), 64'(1));
               end else begin
                  logic [DW:0] e;
                  e = exp_q.pop_front();
                  chk("data", 64'(bus_if.data), 64'(e[DW-1:0]));
                  chk("last", 64'(bus_if.last), 64'(e[DW]));
               end
            end
            if (bus_if.valid && !bus_if.ready) stalls_seen++;
            if (bus_if.ram_en) chk("credit_bound", 64'((issued - delivered) <= int'(SKID)), 64'(1));
            prev_stall = bus_if.valid && !bus_if.ready;
            prev_data  = bus_if.data;
            prev_last  = bus_if.last;
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 right after the accepting edge
   task automatic send_cmd(input int a, input int l);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_addr  = AW'(a);
      bus_if.cmd_len   = LW'(l);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus_if.cmd_ready) begin
            acc_cyc = cyc;
            for (int k = 0; k <= l; k++)
               exp_q.push_back({1'(k == l), DW'((a + k) % int'(DEPTH))});
            @(posedge clk);
            #1;
            bus_if.cmd_valid = 1'b0;
            return;
         end
      end
      chk("cmd_accept_timeout", 64'(bus_if.cmd_ready), 64'(1));
      bus_if.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      for (n = 0; n < 2000; n++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) break;
      end
      if (n == 2000) chk("drain_timeout_qsize", 64'(exp_q.size()), 64'(0));
      @(negedge clk);
      chk("busy_after_drain", 64'(busy), 64'(0));
      chk("valid_after_drain", 64'(bus_if.valid), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      issued = 0; delivered = 0; words_seen = 0; stalls_seen = 0;
   endtask

   initial begin
      int base, s0;
      for (int k = 0; k < int'(DEPTH); k++) mem[k] = DW'(k);
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_addr  = '0;
      bus_if.cmd_len   = '0;
      clear_counts();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'(0));
      chk("rst_ram_en", 64'(bus_if.ram_en), 64'(0));
      chk("rst_valid", 64'(bus_if.valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_stat_words", 64'(stat_words), 64'(0));
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic transfer: latency and back-to-back delivery
      seen_first = 1'b0;
      send_cmd(5, 3);
      drain();
      chk("first_latency", 64'(first_cyc - acc_cyc), 64'(DLY + 2));
      chk("burst_span", 64'(last_hs_cyc - first_cyc), 64'(3));

      // Address wrap at a non power-of-two depth without a stall
      seen_first = 1'b0;
      send_cmd(998, 3);
      drain();
      chk("wrap_span", 64'(last_hs_cyc - first_cyc), 64'(3));

      // Alternating backpressure
      ready_mode = 2;
      send_cmd(7, 15);
      drain();
      ready_mode = 0;

      // Back-to-back commands: one idle issue cycle between them
      en_cyc.delete();
      send_cmd(0, 1);
      send_cmd(100, 0);
      drain();
      chk("b2b_issue_count", 64'(en_cyc.size()), 64'(3));
      if (en_cyc.size() >= 3) begin
         chk("b2b_first_gap", 64'(en_cyc[1] - en_cyc[0]), 64'(1));
         chk("b2b_bubble_gap", 64'(en_cyc[2] - en_cyc[1]), 64'(2));
      end

      // Random commands under random backpressure
      ready_mode = 1;
      for (int i = 0; i < 12; i++) begin
         send_cmd(int'($urandom % DEPTH), int'($urandom % 20));
         if ($urandom % 2 == 0) drain();
      end
      drain();
      ready_mode = 0;

      // Asynchronous reset in the middle of a transfer
      base = words_seen;
      send_cmd(200, 15);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         #1;
         if (words_seen >= base + 2) break;
      end
      chk("pre_reset_words", 64'(words_seen >= base + 2), 64'(1));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cmd_ready", 64'(bus_if.cmd_ready), 64'(0));
      chk("arst_ram_en", 64'(bus_if.ram_en), 64'(0));
      chk("arst_ram_addr", 64'(bus_if.ram_addr), 64'(0));
      chk("arst_valid", 64'(bus_if.valid), 64'(0));
      chk("arst_data", 64'(bus_if.data), 64'(0));
      chk("arst_last", 64'(bus_if.last), 64'(0));
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_stat_words", 64'(stat_words), 64'(0));
      chk("arst_stat_stall", 64'(stat_stall), 64'(0));
      exp_q.delete();
      clear_counts();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send_cmd(50, 0);
      drain();
      repeat (5) @(posedge clk);
      #1;
      chk("post_reset_words", 64'(words_seen), 64'(1));

      // Exactly five stall cycles on an eight-word command
      ready_mode = 4;
      s0 = stalls_seen;
      send_cmd(300, 7);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         #1;
         if (stalls_seen >= s0 + 5) break;
      end
      ready_mode = 0;
      drain();
      chk("model_words", 64'(words_seen), 64'(9));
      chk("model_stalls", 64'(stalls_seen), 64'(5));
`ifdef RAM_RD_STREAM_STATS_EN
      chk("stat_words", 64'(stat_words), 64'(words_seen));
      chk("stat_stall", 64'(stat_stall), 64'(stalls_seen));
`else
      chk("stat_words_off", 64'(stat_words), 64'(0));
      chk("stat_stall_off", 64'(stat_stall), 64'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
